// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C target receive path.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_WIDTH_DFLT = 7;
    localparam int unsigned I2C_DATA_WIDTH_DFLT = 8;

    // R/W bit value on the wire for a master write.
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAckAddr,
        StData,
        StAckData,
        StIgnore
    } i2c_rx_state_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid, ready, last.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes the asynchronous SCL/SDA lines and derives edge and START/STOP pulses.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2 // must be >= 2
) (
    input  logic clk,
    input  logic arstn,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Shift chains plus one extra stage of history for edge detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Reset to the idle-bus level (both high) so release never fakes an edge.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // Pulses; START/STOP require SCL high on both sides of the SDA transition.
    always_comb begin
        sda_o    = sda_s;
        scl_rise = scl_s & ~scl_prev_q;
        scl_fall = ~scl_s & scl_prev_q;
        start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/axis_i2c_target_rx.sv
// Write-only I2C target: matches the address, ACKs bytes and streams them out over AXIS.
module axis_i2c_target_rx #(
    parameter int unsigned                    I2C_ADDR_WIDTH = i2c_pkg::I2C_ADDR_WIDTH_DFLT,
    parameter int unsigned                    I2C_DATA_WIDTH = i2c_pkg::I2C_DATA_WIDTH_DFLT,
    parameter logic [I2C_ADDR_WIDTH-1:0]      TARGET_ADDR    = 7'h50,
    parameter int unsigned                    SYNC_STAGES    = 2
) (
    input  logic   clk,
    input  logic   arstn,
    input  logic   scl_i,
    input  logic   sda_i,
    output logic   sda_oe,
    output logic   busy,
    output logic   ovf,
    axis_if.master m_axis
);

    import i2c_pkg::*;

    localparam int unsigned ADDR_BITS = I2C_ADDR_WIDTH + 1;
    localparam int unsigned SHW       = (ADDR_BITS > I2C_DATA_WIDTH) ? ADDR_BITS : I2C_DATA_WIDTH;
    localparam int unsigned CNT_W     = $clog2(SHW + 1);

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .arstn    (arstn),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_o    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SHW-1:0]            shreg_q, shreg_d;
    logic                      nack_skip_q, nack_skip_d;
    logic                      sda_oe_q, sda_oe_d;
    logic                      busy_q, busy_d;
    logic                      ovf_q, ovf_d;
    logic [I2C_DATA_WIDTH-1:0] hold_q, hold_d;
    logic                      hold_vld_q, hold_vld_d;
    logic                      flush_pend_q, flush_pend_d;
    logic [I2C_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tlast_q, tlast_d;

    logic [SHW-1:0] shift_w;
    logic           out_free, accept, byte_push, byte_drop, frame_end;

    assign shift_w  = {shreg_q[SHW-2:0], sda_s};
    assign out_free = ~tvalid_q | m_axis.tready;
    // A flush in progress blocks new bytes so the frame's last beat keeps its tlast.
    assign accept   = ~flush_pend_q & (~hold_vld_q | out_free);

    // Bus-side FSM: bit shifting, address match, ACK drive and accept decision.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        nack_skip_d = nack_skip_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        byte_push   = 1'b0;
        byte_drop   = 1'b0;
        frame_end   = 1'b0;

        if (start) begin
            state_d     = StAddr;
            bit_cnt_d   = '0;
            nack_skip_d = 1'b0;
            sda_oe_d    = 1'b0;
            frame_end   = 1'b1;
        end else if (stop) begin
            state_d     = StIdle;
            bit_cnt_d   = '0;
            nack_skip_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            frame_end   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: ;
                StAddr: begin
                    if (scl_rise) begin
                        shreg_d   = shift_w;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                            bit_cnt_d = '0;
                            if (shift_w[ADDR_BITS-1:1] == TARGET_ADDR && shift_w[0] == RW_WRITE) begin
                                state_d = StAckAddr;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                // sda_oe_q doubles as the phase: low = waiting for the fall after bit 8.
                StAckAddr, StAckData: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StData;
                        end
                    end
                end
                StData: begin
                    if (scl_rise) begin
                        if (nack_skip_q) begin
                            // The 9th clock of a NACKed byte carries no data.
                            nack_skip_d = 1'b0;
                        end else begin
                            shreg_d   = shift_w;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(I2C_DATA_WIDTH - 1)) begin
                                bit_cnt_d = '0;
                                if (accept) begin
                                    byte_push = 1'b1;
                                    state_d   = StAckData;
                                end else begin
                                    byte_drop   = 1'b1;
                                    nack_skip_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Hold register, output slot and overflow flag.
    always_comb begin
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        flush_pend_d = flush_pend_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        ovf_d        = ovf_q;

        if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
        end

        if (byte_push) begin
            if (hold_vld_q) begin
                tdata_d  = hold_q;
                tlast_d  = 1'b0;
                tvalid_d = 1'b1;
            end
            hold_d     = shift_w[I2C_DATA_WIDTH-1:0];
            hold_vld_d = 1'b1;
        end else if (flush_pend_q && hold_vld_q && out_free) begin
            tdata_d      = hold_q;
            tlast_d      = 1'b1;
            tvalid_d     = 1'b1;
            hold_vld_d   = 1'b0;
            flush_pend_d = 1'b0;
        end

        if (frame_end && hold_vld_d) begin
            flush_pend_d = 1'b1;
        end

        if (start) begin
            ovf_d = 1'b0;
        end else if (byte_drop && !flush_pend_q) begin
            ovf_d = 1'b1;
        end
    end

    // State registers; asynchronous reset drops sda_oe immediately.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            nack_skip_q  <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            nack_skip_q  <= nack_skip_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            flush_pend_q <= flush_pend_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
        end
    end

    assign sda_oe        = sda_oe_q;
    assign busy          = busy_q;
    assign ovf           = ovf_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_axis_i2c_target_rx.sv
// Bench for axis_i2c_target_rx: bit-banged I2C master, AXIS scoreboard.
module tb_axis_i2c_target_rx;

    localparam int unsigned Q = 100; // quarter SCL period in ns (clk is 10 ns)

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_i;
    logic sda_oe, busy, ovf;
    logic oe_seen = 1'b0;
    logic ack;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] exp_q[$]; // {tlast, tdata}
    logic [8:0] exp_beat;

    axis_if #(.DATA_WIDTH(8)) axis_bus ();

    // Open-drain wired-AND of master and target.
    assign sda_i = sda_m & ~sda_oe;

    axis_i2c_target_rx #(
        .I2C_ADDR_WIDTH (7),
        .I2C_DATA_WIDTH (8),
        .TARGET_ADDR    (7'h50),
        .SYNC_STAGES    (2)
    ) dut (
        .clk    (clk),
        .arstn  (arstn),
        .scl_i  (scl_m),
        .sda_i  (sda_i),
        .sda_oe (sda_oe),
        .busy   (busy),
        .ovf    (ovf),
        .m_axis (axis_bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every completed handshake against the head of the queue.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (arstn && axis_bus.tvalid && axis_bus.tready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", {23'd0, axis_bus.tlast, axis_bus.tdata}, 32'hFFFF_FFFF);
            end else begin
                exp_beat = exp_q.pop_front();
                check_eq("beat", {23'd0, axis_bus.tlast, axis_bus.tdata}, {23'd0, exp_beat});
            end
        end
    end

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 axis_bus.tready = r;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        a = ~sda_i; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        axis_bus.tready = 1'b1;
        #23;
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_tvalid", axis_bus.tvalid, 0);
        check_eq("rst_tlast", axis_bus.tlast, 0);
        check_eq("rst_tdata", axis_bus.tdata, 0);
        @(posedge clk); #1 arstn = 1'b1;
        repeat (5) @(posedge clk);

        // 1: basic two-byte write
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'h3C});
        bus_start();
        send_byte(8'hA0, ack); check_eq("t1_addr_ack", ack, 1);
        check_eq("t1_busy", busy, 1);
        send_byte(8'hA5, ack); check_eq("t1_d0_ack", ack, 1);
        send_byte(8'h3C, ack); check_eq("t1_d1_ack", ack, 1);
        bus_stop();
        check_eq("t1_busy_stop", busy, 0);
        drain("t1_drained");

        // 2: other address is ignored
        oe_seen = 1'b0;
        bus_start();
        send_byte(8'hA2, ack); check_eq("t2_addr_nack", ack, 0);
        send_byte(8'h12, ack); check_eq("t2_d0_nack", ack, 0);
        send_byte(8'h34, ack); check_eq("t2_d1_nack", ack, 0);
        check_eq("t2_busy", busy, 0);
        bus_stop();
        check_eq("t2_oe_seen", oe_seen, 0);

        // 3: read request is NACKed, following write works
        bus_start();
        send_byte(8'hA1, ack); check_eq("t3_read_nack", ack, 0);
        check_eq("t3_busy", busy, 0);
        send_byte(8'h99, ack); check_eq("t3_ign_nack", ack, 0);
        bus_stop();
        exp_q.push_back({1'b1, 8'h5A});
        bus_start();
        send_byte(8'hA0, ack); check_eq("t3_addr_ack", ack, 1);
        send_byte(8'h5A, ack); check_eq("t3_d0_ack", ack, 1);
        bus_stop();
        drain("t3_drained");

        // 4: backpressure overflow
        set_ready(1'b0);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        bus_start();
        send_byte(8'hA0, ack); check_eq("t4_addr_ack", ack, 1);
        send_byte(8'h11, ack); check_eq("t4_d0_ack", ack, 1);
        check_eq("t4_ovf_clear", ovf, 0);
        send_byte(8'h22, ack); check_eq("t4_d1_ack", ack, 1);
        check_eq("t4_tvalid", axis_bus.tvalid, 1);
        check_eq("t4_tdata", axis_bus.tdata, 8'h11);
        send_byte(8'h33, ack); check_eq("t4_d2_nack", ack, 0);
        check_eq("t4_ovf_set", ovf, 1);
        check_eq("t4_tdata_hold", axis_bus.tdata, 8'h11);
        check_eq("t4_tlast_hold", axis_bus.tlast, 0);
        bus_stop();
        check_eq("t4_ovf_sticky", ovf, 1);
        set_ready(1'b1);
        drain("t4_drained");

        // 5: repeated START ends the first frame
        exp_q.push_back({1'b1, 8'h77});
        exp_q.push_back({1'b1, 8'h88});
        bus_start();
        check_eq("t5_ovf_start", ovf, 0);
        send_byte(8'hA0, ack); check_eq("t5_addr0_ack", ack, 1);
        send_byte(8'h77, ack); check_eq("t5_d0_ack", ack, 1);
        bus_start();
        send_byte(8'hA0, ack); check_eq("t5_addr1_ack", ack, 1);
        send_byte(8'h88, ack); check_eq("t5_d1_ack", ack, 1);
        bus_stop();
        drain("t5_drained");

        // 6: reset in the middle of a data byte
        bus_start();
        send_byte(8'hA0, ack); check_eq("t6_addr_ack", ack, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check_eq("t6_busy_pre", busy, 1);
        arstn = 1'b0;
        #1;
        check_eq("t6_rst_sda_oe", sda_oe, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_ovf", ovf, 0);
        check_eq("t6_rst_tvalid", axis_bus.tvalid, 0);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        @(posedge clk); #1 arstn = 1'b1;
        repeat (5) @(posedge clk);
        exp_q.push_back({1'b1, 8'h96});
        bus_start();
        send_byte(8'hA0, ack); check_eq("t6_addr_ack2", ack, 1);
        send_byte(8'h96, ack); check_eq("t6_d0_ack", ack, 1);
        bus_stop();
        check_eq("t6_busy_end", busy, 0);
        drain("t6_drained");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
